// File: rtl/mult_seq_ctrl_if.sv
// Operand/result bundle for the sequential multiplier: the requester drives START,
// SIGNED, A and B; the multiplier returns BUSY, DONE and the HI/LO product halves.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SIGNED;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output START, SIGNED, A, B,
        input  BUSY, DONE, HI, LO
    );

    modport slave (
        input  START, SIGNED, A, B,
        output BUSY, DONE, HI, LO
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Iterative radix-2 shift-add multiplier: one add/shift step per clock into a 2*WIDTH product.
// Optional feature macro MULT_SIGNED_EN: signed operands via magnitudes plus a final FIX negation.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    mult_seq_ctrl_if.slave     bus
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   add_sum;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef MULT_SIGNED_EN
    logic sign_q, sign_d;
    logic sign_in;

    // Signed ops run on magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_mag   = (bus.SIGNED && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag   = (bus.SIGNED && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
        sign_in = bus.SIGNED & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    end
`else
    logic unused_signed;

    assign a_mag         = bus.A;
    assign b_mag         = bus.B;
    assign unused_signed = bus.SIGNED;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a hold/default value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        add_sum = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, m_q};
`ifdef MULT_SIGNED_EN
        sign_d  = sign_q;
`endif

        case (state_q)
            // DONE accepts a new request exactly like IDLE so operations can run back-to-back.
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    p_d     = {{WIDTH{1'b0}}, b_mag};
                    m_d     = a_mag;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef MULT_SIGNED_EN
                    sign_d  = sign_in;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (p_q[0]) begin
                    p_d = {add_sum, p_q[WIDTH-1:1]};
                end else begin
                    p_d = {1'b0, p_q[PW-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
`ifdef MULT_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef MULT_SIGNED_EN
            S_FIX: begin
                if (sign_q) begin
                    p_d = ~p_q + PW'(1);
                end
                state_d = S_DONE;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result halves are captured only on the transition into DONE and hold afterwards.
        if (state_d == S_DONE && state_q != S_DONE) begin
            hi_d = p_d[PW-1:WIDTH];
            lo_d = p_d[WIDTH-1:0];
        end
    end

    assign bus.BUSY = (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.DONE = (state_q == S_DONE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: a cycle-level timing/product model checked every
// cycle, plus directed operations with hand-computed literal products and latencies.
module tb_mult_seq_ctrl;

    localparam int W = 32;
`ifdef MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product from plain arithmetic: sign-extend for signed ops, then take the low 64 bits.
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {32'b0, a};
        bx = {32'b0, b};
`ifdef MULT_SIGNED_EN
        if (s) begin
            ax = {{32{a[31]}}, a};
            bx = {{32{b[31]}}, b};
        end
`else
        if (s) begin
            ax = {32'b0, a};
        end
`endif
        return ax * bx;
    endfunction

    // Model: an accepted request makes the unit busy for LAT cycles, then a one-cycle DONE.
    int          m_left;
    logic        m_done;
    logic [63:0] m_prod;
    logic [63:0] m_res;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_prod;
                end
            end else if (bus.START) begin
                m_left = LAT;
                m_prod = model_prod(bus.A, bus.B, bus.SIGNED);
            end
        end
    end

    always @(negedge CLK) begin
        check("cmp_busy", bus.BUSY, (m_left > 0));
        check("cmp_done", bus.DONE, m_done);
        check("cmp_hi", bus.HI, m_res[63:32]);
        check("cmp_lo", bus.LO, m_res[31:0]);
        check("cmp_busy_done_excl", bus.BUSY & bus.DONE, 1'b0);
    end

    // Starts at the current negedge; returns at the negedge where DONE is seen.
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp, input bit inject);
        int cyc    = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        bus.A      = a;
        bus.B      = b;
        bus.SIGNED = s;
        bus.START  = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                bus.START = 1'b0;
                check({name, "_busy_after_start"}, bus.BUSY, 1'b1);
            end
            if (inject && cyc == 10) begin
                bus.A     = 32'd2;
                bus.B     = 32'd2;
                bus.START = 1'b1;
            end
            if (inject && cyc == 11) begin
                bus.START  = 1'b0;
                bus.A      = 32'hDEAD_BEEF;
                bus.B      = 32'h0000_1234;
                bus.SIGNED = ~s;
            end
            if (bus.BUSY) busy_n++;
            if (bus.DONE) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_latency"}, cyc, LAT + 1);
        check({name, "_busy_cycles"}, busy_n, LAT);
        check({name, "_hi"}, bus.HI, exp[63:32]);
        check({name, "_lo"}, bus.LO, exp[31:0]);
    endtask

    initial begin
        int late_done;
        bus.START  = 1'b0;
        bus.SIGNED = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        RST        = 1'b0;
        #1 RST     = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_hi", bus.HI, 32'h0);
        check("rst_lo", bus.LO, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        do_op("u_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
        @(negedge CLK);
        do_op("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        @(negedge CLK);
        do_op("u_zero", 32'h0, 32'h1234_5678, 1'b0, 64'h0, 1'b0);
        @(negedge CLK);
        do_op("u_7x9_ignored_start", 32'd7, 32'd9, 1'b0, 64'd63, 1'b1);
        do_op("u_b2b_2x2", 32'd2, 32'd2, 1'b0, 64'd4, 1'b0);
        @(negedge CLK);

        // Reset in the middle of a run: everything clears immediately and no DONE follows.
        bus.A     = 32'h0001_0000;
        bus.B     = 32'h0001_0000;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (9) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("midrst_busy", bus.BUSY, 1'b0);
        check("midrst_done", bus.DONE, 1'b0);
        check("midrst_hi", bus.HI, 32'h0);
        check("midrst_lo", bus.LO, 32'h0);
        @(negedge CLK);
        #2 RST = 1'b0;
        late_done = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.DONE) late_done++;
        end
        check("midrst_no_done", late_done, 0);

        do_op("after_rst", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
        @(negedge CLK);

`ifdef MULT_SIGNED_EN
        do_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        @(negedge CLK);
        do_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        @(negedge CLK);
        do_op("u_fffdx5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b0);
`else
        do_op("sig_ignored", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, 1'b0);
`endif
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Iterative radix-2 shift-add multiply controller for the ALU multiply path.
- Accepts two 32-bit operands with a START pulse and sequences one add/shift step per clock through an internal 64-bit product register.
- Presents the 64-bit product on HI/LO with a one-cycle DONE pulse.
- Replaces the fully unrolled array multiplier where area matters; a MULT/MULTU instruction stalls on BUSY.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous, active-high reset
START  input  1  request pulse; sampled only in IDLE or DONE state
SIGNED  input  1  signed-operation select; sampled with START (ignored unless MULT_SIGNED_EN)
A  input  WIDTH  multiplicand, sampled with START
B  input  WIDTH  multiplier, sampled with START
BUSY  output  1  high while the operation is in progress (RUN or FIX)
DONE  output  1  one-cycle pulse; HI/LO valid from this cycle
HI  output  WIDTH  upper half of product
LO  output  WIDTH  lower half of product

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - state=IDLE; BUSY=0, DONE=0, HI=0, LO=0.
  - Product register P=0, multiplicand register M=0, counter=0, sign flag=0.
- States: IDLE, RUN, FIX (only with macro), DONE.
- IDLE, START=1 at edge k:
  - Load P={0,B'}, M=A', counter=0; go to RUN.
  - A' and B' are the operands, or their magnitudes in a signed op.
- RUN, each edge:
  - If P[0]=1: {c,S}=P[63:32]+M (33-bit add), then P={c,S,P[31:1]}.
  - Else P={1'b0,P[63:1]}.
  - Increment the counter.
  - When counter==WIDTH-1 at the edge, the step still executes. Next state is FIX (macro on) or DONE.
  - The counter never wraps. It resets to 0 on load.
- FIX: if the sign flag is set, P=~P+1 (64-bit two's complement); else P is unchanged. Go to DONE.
- DONE: DONE=1 for exactly one cycle; HI=P[63:32], LO=P[31:0].
  - HI/LO are registered on entry to DONE.
  - HI/LO hold until the next entry to DONE or reset.
  - Next state is IDLE. If START=1 in the DONE cycle, a new operation loads and the next state is RUN (back-to-back).
- Latency:
  - START at edge k gives DONE high in the cycle following edge k+32 (33 cycles) without the macro.
  - With the macro it is k+33 (34 cycles), uniform for signed and unsigned operations.
- BUSY=1 exactly in RUN/FIX. BUSY and DONE are never high together.
- START while BUSY is ignored. Operands are not re-sampled and no queueing occurs.
- A, B and SIGNED changing during RUN have no effect.
- RST mid-operation: immediate return to reset values. No DONE is issued and HI/LO clear to 0.
- Arithmetic is modulo 2^64; overflow is impossible for WIDTH-bit operands.

Optional Feature:
MULT_SIGNED_EN
- Defined:
  - At START, if SIGNED=1: A'=A[31]?-A:A and B'=B[31]?-B:B (32-bit unsigned magnitudes; 0x80000000 maps to 2^31), and sign flag=A[31]^B[31].
  - If SIGNED=0: magnitudes are the raw operands and sign flag=0.
  - The FIX state is present.
- Not defined: the SIGNED port is ignored, there is no FIX state, all operations are unsigned, and latency is 33 cycles.

Test Plan:
- Reset, then START with A=3, B=5, SIGNED=0 → BUSY high for 32 cycles (33 with macro), DONE single pulse, HI=0x00000000, LO=0x0000000F.
- A=0xFFFFFFFF, B=0xFFFFFFFF unsigned → HI=0xFFFFFFFE, LO=0x00000001. A=0, B=0x12345678 → HI=0, LO=0.
- Operation A=7, B=9 running; pulse START with A=2, B=2 at cycle 10 → ignored, result LO=63. Then assert START in the DONE cycle with A=2, B=2 → next result LO=4 with no IDLE cycle.
- RST asserted at RUN cycle 10 of A=0x10000, B=0x10000 → BUSY=0 and HI=LO=0 immediately, no DONE pulse. A subsequent operation completes normally.
- MULT_SIGNED_EN, SIGNED=1:
  - A=0xFFFFFFFD (-3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1, DONE at 34 cycles.
  - A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- MULT_SIGNED_EN, SIGNED=0, A=0xFFFFFFFD, B=5 → HI=0x00000004, LO=0xFFFFFFF1, DONE at 34 cycles.
